// File: rtl/pic_pkg.sv
// Shared encodings for the PIC priority/acknowledge block: OCW2 commands,
// INTA sequencer states and command-word bit positions.
package pic_pkg;

    localparam logic [2:0] ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] EOI_NS       = 3'b001;
    localparam logic [2:0] EOI_SP       = 3'b011;
    localparam logic [2:0] ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] ROT_NS       = 3'b101;
    localparam logic [2:0] SET_PRI      = 3'b110;
    localparam logic [2:0] ROT_SP       = 3'b111;

    localparam int LTIM_BIT = 3;
    localparam int AEOI_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } inta_state_t;

    // Position of a level in the scan order that starts just after lp;
    // a smaller rank means higher priority.
    function automatic logic [2:0] scan_rank(input logic [2:0] lvl, input logic [2:0] lp);
        return lvl - lp - 3'd1;
    endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Rotating first-set finder: scans levels lp+1, lp+2, ..., lp (3-bit wrap)
// and reports the first set bit of the vector.
module pic_prio_resolver (
    input  logic [7:0] i_vec,
    input  logic [2:0] i_lp,
    output logic       o_found,
    output logic [2:0] o_lvl
);

    logic       w_hit;
    logic [2:0] w_lvl;
    logic [2:0] w_idx;

    always_comb begin
        w_hit = 1'b0;
        w_lvl = 3'd0;
        w_idx = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            w_idx = i_lp + 3'(k);
            if (!w_hit && i_vec[w_idx]) begin
                w_hit = 1'b1;
                w_lvl = w_idx;
            end
        end
    end

    assign o_found = w_hit;
    assign o_lvl   = w_lvl;

endmodule

// File: rtl/pic_priority_ack.sv
// PIC IRR/ISR, priority resolution, INT generation, 8086 INTA sequencer and
// OCW2 handling. Optional macro PIC_IR_SYNC_EN adds 2-flop input synchronizers.
//
// state | meaning
// IDLE  | waiting for the first INTA falling edge
// ACK1  | level latched and ISR set, waiting for the second falling edge
// ACK2  | vector byte driven until INTA rises
module pic_priority_ack
    import pic_pkg::*;
#(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7,
    parameter logic [2:0] RESET_LP       = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir,
    input  logic       inta_n,
    input  logic       icw1_wr,
    input  logic       init_done,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw4,
    input  logic [7:0] ocw1,
    input  logic [7:0] ocw2,
    input  logic       ocw2_wr,
    output logic       int_o,
    output logic [7:0] data_o,
    output logic       data_oe,
    output logic [7:0] irr_o,
    output logic [7:0] isr_o
);

    logic [7:0]  w_ir;
    logic        w_inta_n;

`ifdef PIC_IR_SYNC_EN
    logic [7:0]  r_ir_s1;
    logic [7:0]  r_ir_s2;
    logic        r_inta_s1;
    logic        r_inta_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir_s1   <= 8'h00;
            r_ir_s2   <= 8'h00;
            r_inta_s1 <= 1'b1;
            r_inta_s2 <= 1'b1;
        end else begin
            r_ir_s1   <= ir;
            r_ir_s2   <= r_ir_s1;
            r_inta_s1 <= inta_n;
            r_inta_s2 <= r_inta_s1;
        end
    end

    assign w_ir     = r_ir_s2;
    assign w_inta_n = r_inta_s2;
`else
    assign w_ir     = ir;
    assign w_inta_n = inta_n;
`endif

    logic [7:0]  r_irr;
    logic [7:0]  r_isr;
    logic        r_int;
    logic [7:0]  r_data;
    logic        r_data_oe;
    logic [2:0]  r_lp;
    logic        r_rot_aeoi;
    inta_state_t r_state;
    logic [7:0]  r_ir_prev;
    logic        r_inta_prev;
    logic [2:0]  r_ack_lvl;
    logic        r_spurious;

    logic [7:0]  w_irr_nxt;
    logic [7:0]  w_isr_nxt;
    logic        w_int_nxt;
    logic [7:0]  w_data_nxt;
    logic        w_oe_nxt;
    logic [2:0]  w_lp_nxt;
    logic        w_rot_nxt;
    inta_state_t w_state_nxt;
    logic [2:0]  w_ack_nxt;
    logic        w_spur_nxt;

    logic [7:0]  w_irr_smp;
    logic [7:0]  w_irr_clr;
    logic [7:0]  w_isr_set;
    logic [7:0]  w_isr_clr;

    logic        w_req_found;
    logic [2:0]  w_req_lvl;
    logic        w_isr_found;
    logic [2:0]  w_isr_lvl;
    logic        w_req_first;
    logic        w_inta_fall;
    logic        w_inta_rise;
    logic [2:0]  w_ocw2_cmd;
    logic [2:0]  w_ocw2_lvl;

    pic_prio_resolver u_req_res (
        .i_vec   (r_irr & ~ocw1),
        .i_lp    (r_lp),
        .o_found (w_req_found),
        .o_lvl   (w_req_lvl)
    );

    pic_prio_resolver u_isr_res (
        .i_vec   (r_isr),
        .i_lp    (r_lp),
        .o_found (w_isr_found),
        .o_lvl   (w_isr_lvl)
    );

    // A request equal to the in-service level does not preempt it.
    assign w_req_first = w_req_found &
                         (~w_isr_found |
                          (scan_rank(w_req_lvl, r_lp) < scan_rank(w_isr_lvl, r_lp)));

    assign w_inta_fall = r_inta_prev & ~w_inta_n;
    assign w_inta_rise = ~r_inta_prev & w_inta_n;
    assign w_ocw2_cmd  = ocw2[7:5];
    assign w_ocw2_lvl  = ocw2[2:0];

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = r_ack_lvl;
        w_spur_nxt  = r_spurious;
        w_data_nxt  = r_data;
        w_oe_nxt    = r_data_oe;
        w_lp_nxt    = r_lp;
        w_rot_nxt   = r_rot_aeoi;
        w_int_nxt   = init_done & w_req_first;
        w_irr_clr   = 8'h00;
        w_isr_set   = 8'h00;
        w_isr_clr   = 8'h00;

        if (icw1[LTIM_BIT]) begin
            w_irr_smp = w_ir;
        end else begin
            w_irr_smp = w_ir & (r_irr | ~r_ir_prev);
        end

        if (init_done) begin
            case (r_state)
                IDLE: begin
                    if (w_inta_fall) begin
                        w_state_nxt = ACK1;
                        w_int_nxt   = 1'b0;
                        if (w_req_found) begin
                            w_ack_nxt              = w_req_lvl;
                            w_spur_nxt             = 1'b0;
                            w_isr_set[w_req_lvl]   = 1'b1;
                            w_irr_clr[w_req_lvl]   = 1'b1;
                        end else begin
                            w_ack_nxt  = SPURIOUS_LEVEL;
                            w_spur_nxt = 1'b1;
                        end
                    end
                end
                ACK1: begin
                    if (w_inta_fall) begin
                        w_state_nxt = ACK2;
                        w_data_nxt  = {icw2[7:3], r_ack_lvl};
                        w_oe_nxt    = 1'b1;
                    end
                end
                ACK2: begin
                    if (w_inta_rise) begin
                        w_state_nxt = IDLE;
                        w_oe_nxt    = 1'b0;
                        if (icw4[AEOI_BIT]) begin
                            if (!r_spurious) begin
                                w_isr_clr[r_ack_lvl] = 1'b1;
                            end
                            if (r_rot_aeoi) begin
                                w_lp_nxt = r_ack_lvl;
                            end
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end

        if (ocw2_wr) begin
            case (w_ocw2_cmd)
                EOI_NS: begin
                    if (w_isr_found) begin
                        w_isr_clr[w_isr_lvl] = 1'b1;
                    end
                end
                EOI_SP: w_isr_clr[w_ocw2_lvl] = 1'b1;
                ROT_NS: begin
                    if (w_isr_found) begin
                        w_isr_clr[w_isr_lvl] = 1'b1;
                        w_lp_nxt             = w_isr_lvl;
                    end
                end
                ROT_SP: begin
                    w_isr_clr[w_ocw2_lvl] = 1'b1;
                    w_lp_nxt              = w_ocw2_lvl;
                end
                SET_PRI:      w_lp_nxt  = w_ocw2_lvl;
                ROT_AEOI_SET: w_rot_nxt = 1'b1;
                ROT_AEOI_CLR: w_rot_nxt = 1'b0;
                default: ;
            endcase
        end

        // Clears use the pre-cycle ISR; a same-cycle ACK1 set wins.
        w_irr_nxt = w_irr_smp & ~w_irr_clr;
        w_isr_nxt = (r_isr & ~w_isr_clr) | w_isr_set;

        if (icw1_wr) begin
            w_irr_nxt   = 8'h00;
            w_isr_nxt   = 8'h00;
            w_lp_nxt    = RESET_LP;
            w_rot_nxt   = 1'b0;
            w_state_nxt = IDLE;
            w_oe_nxt    = 1'b0;
            w_int_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irr       <= 8'h00;
            r_isr       <= 8'h00;
            r_int       <= 1'b0;
            r_data      <= 8'h00;
            r_data_oe   <= 1'b0;
            r_lp        <= RESET_LP;
            r_rot_aeoi  <= 1'b0;
            r_state     <= IDLE;
            r_ir_prev   <= 8'h00;
            r_inta_prev <= 1'b1;
            r_ack_lvl   <= 3'd0;
            r_spurious  <= 1'b0;
        end else begin
            r_irr       <= w_irr_nxt;
            r_isr       <= w_isr_nxt;
            r_int       <= w_int_nxt;
            r_data      <= w_data_nxt;
            r_data_oe   <= w_oe_nxt;
            r_lp        <= w_lp_nxt;
            r_rot_aeoi  <= w_rot_nxt;
            r_state     <= w_state_nxt;
            r_ir_prev   <= w_ir;
            r_inta_prev <= w_inta_n;
            r_ack_lvl   <= w_ack_nxt;
            r_spurious  <= w_spur_nxt;
        end
    end

    logic w_unused;
    assign w_unused = ^{icw1[7:4], icw1[2:0], icw2[2:0], icw4[7:2], icw4[0], ocw2[4:3]};

    assign int_o   = r_int;
    assign data_o  = r_data;
    assign data_oe = r_data_oe;
    assign irr_o   = r_irr;
    assign isr_o   = r_isr;

endmodule

// File: tb/tb_pic_priority_ack.sv
// Scoreboard bench for pic_priority_ack: a behavioural model predicts the
// registered outputs each cycle; a monitor compares them on the falling edge.
module tb_pic_priority_ack;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ir = 8'h00;
    logic       inta_n = 1'b1;
    logic       icw1_wr = 1'b0;
    logic       init_done = 1'b0;
    logic [7:0] icw1 = 8'h00;
    logic [7:0] icw2 = 8'h00;
    logic [7:0] icw4 = 8'h00;
    logic [7:0] ocw1 = 8'h00;
    logic [7:0] ocw2 = 8'h00;
    logic       ocw2_wr = 1'b0;
    logic       int_o;
    logic [7:0] data_o;
    logic       data_oe;
    logic [7:0] irr_o;
    logic [7:0] isr_o;

    always #5 clk = ~clk;

    pic_priority_ack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir        (ir),
        .inta_n    (inta_n),
        .icw1_wr   (icw1_wr),
        .init_done (init_done),
        .icw1      (icw1),
        .icw2      (icw2),
        .icw4      (icw4),
        .ocw1      (ocw1),
        .ocw2      (ocw2),
        .ocw2_wr   (ocw2_wr),
        .int_o     (int_o),
        .data_o    (data_o),
        .data_oe   (data_oe),
        .irr_o     (irr_o),
        .isr_o     (isr_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] irr;
        logic [7:0] isr;
        logic [7:0] data;
        logic       intr;
        logic       oe;
    } snap_t;

    snap_t exp_q[$];

    // Behavioural model state
    logic [7:0] m_irr, m_isr, m_data, m_ir_prev;
    bit         m_int, m_oe, m_rot, m_spur, m_inta_prev;
    int         m_lp, m_phase, m_ack;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %02h required %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int first_set(input logic [7:0] v, input int lp);
        for (int k = 1; k <= 8; k++) begin
            int l;
            l = (lp + k) % 8;
            if (v[l]) return l;
        end
        return -1;
    endfunction

    function automatic int rank(input int l, input int lp);
        return (l - lp - 1 + 16) % 8;
    endfunction

    task automatic model_reset();
        m_irr = 8'h00; m_isr = 8'h00; m_data = 8'h00; m_ir_prev = 8'h00;
        m_int = 0; m_oe = 0; m_rot = 0; m_spur = 0; m_inta_prev = 1;
        m_lp = 7; m_phase = 0; m_ack = 0;
    endtask

    // One clock: predict from current inputs, advance, publish expectation.
    task automatic cyc();
        logic [7:0] n_irr, n_isr, n_data, clr, set;
        bit         n_int, n_oe, n_rot, n_spur, fall, rise;
        int         n_lp, n_phase, n_ack, req, cur, lvl_l;
        snap_t      s;

        n_irr = m_irr; n_data = m_data; n_oe = m_oe; n_rot = m_rot;
        n_spur = m_spur; n_lp = m_lp; n_phase = m_phase; n_ack = m_ack;
        clr = 8'h00; set = 8'h00;
        fall = m_inta_prev && !inta_n;
        rise = !m_inta_prev && inta_n;
        req = first_set(m_irr & ~ocw1, m_lp);
        cur = first_set(m_isr, m_lp);

        for (int i = 0; i < 8; i++) begin
            if (icw1[3]) n_irr[i] = ir[i];
            else if (!ir[i]) n_irr[i] = 1'b0;
            else if (!m_ir_prev[i]) n_irr[i] = 1'b1;
        end
        n_int = init_done && (req >= 0) && (cur < 0 || rank(req, m_lp) < rank(cur, m_lp));

        if (init_done) begin
            if (m_phase == 0 && fall) begin
                n_phase = 1;
                n_int = 0;
                if (req >= 0) begin
                    n_ack = req; n_spur = 0; set[req] = 1'b1; n_irr[req] = 1'b0;
                end else begin
                    n_ack = 7; n_spur = 1;
                end
            end else if (m_phase == 1 && fall) begin
                n_phase = 2;
                n_data = {icw2[7:3], 3'(m_ack)};
                n_oe = 1;
            end else if (m_phase == 2 && rise) begin
                n_phase = 0;
                n_oe = 0;
                if (icw4[1]) begin
                    if (!m_spur) clr[m_ack] = 1'b1;
                    if (m_rot) n_lp = m_ack;
                end
            end
        end

        if (ocw2_wr) begin
            lvl_l = int'(ocw2[2:0]);
            case (ocw2[7:5])
                3'd1: if (cur >= 0) clr[cur] = 1'b1;
                3'd3: clr[lvl_l] = 1'b1;
                3'd5: if (cur >= 0) begin clr[cur] = 1'b1; n_lp = cur; end
                3'd7: begin clr[lvl_l] = 1'b1; n_lp = lvl_l; end
                3'd6: n_lp = lvl_l;
                3'd4: n_rot = 1;
                3'd0: n_rot = 0;
                default: ;
            endcase
        end
        n_isr = (m_isr & ~clr) | set;

        if (icw1_wr) begin
            n_irr = 8'h00; n_isr = 8'h00; n_lp = 7; n_rot = 0;
            n_phase = 0; n_oe = 0; n_int = 0;
        end

        @(posedge clk);
        m_irr = n_irr; m_isr = n_isr; m_data = n_data; m_int = n_int; m_oe = n_oe;
        m_rot = n_rot; m_spur = n_spur; m_lp = n_lp; m_phase = n_phase; m_ack = n_ack;
        m_ir_prev = ir; m_inta_prev = inta_n;
        s.irr = m_irr; s.isr = m_isr; s.data = m_data; s.intr = m_int; s.oe = m_oe;
        exp_q.push_back(s);
        #1;
    endtask

    task automatic inta_pulse();
        inta_n = 1'b0; cyc(); cyc();
        inta_n = 1'b1; cyc(); cyc();
    endtask

    task automatic ack_seq(input string nm, input logic [7:0] exp_vec);
        inta_pulse();
        inta_n = 1'b0;
        cyc();
        chk(nm, data_o, exp_vec);
        cyc();
        inta_n = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic ocw2_write(input logic [7:0] v);
        ocw2 = v; ocw2_wr = 1'b1;
        cyc();
        ocw2_wr = 1'b0;
    endtask

    // Monitor: compare each published expectation against the DUT.
    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("irr", irr_o, e.irr);
                chk("isr", isr_o, e.isr);
                chk("int", {7'd0, int_o}, {7'd0, e.intr});
                chk("data_oe", {7'd0, data_oe}, {7'd0, e.oe});
                if (e.oe) chk("vector", data_o, e.data);
            end
        end
    end

    initial begin
        logic [7:0] v;
        int act;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_irr", irr_o, 8'h00);
        chk("rst_isr", isr_o, 8'h00);
        chk("rst_int", {7'd0, int_o}, 8'h00);
        chk("rst_oe", {7'd0, data_oe}, 8'h00);
        chk("rst_data", data_o, 8'h00);
        rst_n = 1'b1;
        init_done = 1'b1; icw2 = 8'h40;

        // Edge mode, two requests, level 2 wins
        ir = 8'h24; cyc(); cyc();
        chk("s1_int", {7'd0, int_o}, 8'h01);
        ack_seq("s1_vec", 8'h42);
        chk("s1_isr", isr_o, 8'h04);
        chk("s1_irr", irr_o, 8'h20);

        // Nesting: higher preempts, lower waits for EOI
        ir = 8'h26; cyc(); cyc();
        chk("s2_int_ir1", {7'd0, int_o}, 8'h01);
        ir = 8'h20; cyc(); cyc();
        chk("s2_int_blocked", {7'd0, int_o}, 8'h00);
        ocw2_write(8'h20); cyc();
        chk("s2_int_after_eoi", {7'd0, int_o}, 8'h01);
        ack_seq("s2_vec", 8'h45);
        ocw2_write(8'h20);
        ir = 8'h00; cyc(); cyc();

        // Rotate specific L=3 with simultaneous requests on 0 and 4
        ir = 8'h08; cyc(); cyc();
        ack_seq("s3_pre", 8'h43);
        ir = 8'h00; cyc();
        ir = 8'h11; ocw2_write(8'hE3);
        chk("s3_isr", isr_o, 8'h00);
        cyc();
        ack_seq("s3_vec", 8'h44);
        chk("s3_isr_ack", isr_o, 8'h10);
        ocw2_write(8'h64);
        ack_seq("s3_vec0", 8'h40);
        ocw2_write(8'h60);
        ocw2_write(8'hC7);
        ir = 8'h00; cyc(); cyc();

        // AEOI with rotation
        icw4 = 8'h02; ocw2_write(8'h80);
        ir = 8'h40; cyc(); cyc();
        ack_seq("s4_vec", 8'h46);
        chk("s4_isr", isr_o, 8'h00);
        ir = 8'h81; cyc(); cyc();
        ack_seq("s4_lp6", 8'h47);
        ocw2_write(8'h00);
        icw4 = 8'h00; ir = 8'h00; cyc(); cyc();

        // Spurious acknowledge leaves ISR alone
        ir = 8'h02; cyc(); cyc();
        ack_seq("s5_pre", 8'h41);
        ir = 8'h00; cyc(); cyc();
        ack_seq("s5_spur", 8'h47);
        chk("s5_isr", isr_o, 8'h02);
        ocw2_write(8'h20);

        // icw1_wr during ACK1
        ir = 8'h01; cyc(); cyc();
        inta_pulse();
        chk("s6_isr_pre", isr_o, 8'h01);
        icw1_wr = 1'b1; cyc(); icw1_wr = 1'b0;
        chk("s6_isr", isr_o, 8'h00);
        chk("s6_oe", {7'd0, data_oe}, 8'h00);
        chk("s6_int", {7'd0, int_o}, 8'h00);
        ir = 8'h00; cyc();
        ir = 8'h81; cyc(); cyc();
        ack_seq("s6_lp7", 8'h40);
        ocw2_write(8'h20);
        ir = 8'h00; cyc(); cyc();

        // Asynchronous reset while the vector is driven
        ir = 8'h04; cyc(); cyc();
        inta_pulse();
        inta_n = 1'b0; cyc();
        chk("s7_oe_pre", {7'd0, data_oe}, 8'h01);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s7_oe_async", {7'd0, data_oe}, 8'h00);
        chk("s7_isr_async", isr_o, 8'h00);
        inta_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            act = $urandom_range(0, 9);
            if ($urandom_range(0, 2) == 0) ir = 8'($urandom);
            case (act)
                0, 1, 2: cyc();
                3, 4: inta_pulse();
                5: begin
                    v = 8'($urandom);
                    v[4:3] = 2'b00;
                    ocw2_write(v);
                end
                6: begin
                    ocw1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                    cyc();
                end
                7: begin
                    icw1[3] = ~icw1[3];
                    icw4[1] = 1'($urandom);
                    icw2 = 8'($urandom);
                    cyc();
                end
                8: begin
                    init_done = ($urandom_range(0, 3) != 0);
                    cyc();
                end
                default: begin
                    if ($urandom_range(0, 4) == 0) begin
                        icw1_wr = 1'b1; cyc(); icw1_wr = 1'b0;
                    end else begin
                        cyc();
                    end
                end
            endcase
        end

        inta_n = 1'b1; cyc(); cyc();
        @(negedge clk);
        #1;
        chk("queue_drain", 8'(exp_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
